// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - shared constants, FSM state codes and product sign extension for dot_product_accum
package dot_pkg;

  localparam int PROD_W = 8;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  function automatic logic [31:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(32-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - ACC_W-bit signed adder; clamps when DOT_PRODUCT_ACCUM_SAT_EN is defined, wraps otherwise
module sat_adder #(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_clamp
);

`ifdef DOT_PRODUCT_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_full;

  // One guard bit: the top two bits disagree exactly when the true sum left the range.
  assign w_full  = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};
  assign o_clamp = w_full[ACC_W] ^ w_full[ACC_W-1];
  assign o_sum   = o_clamp ? (w_full[ACC_W] ? MIN_V : MAX_V) : w_full[ACC_W-1:0];
`else
  assign o_sum   = i_a + i_b;
  assign o_clamp = 1'b0;
`endif

endmodule

// File: rtl/dot_product_accum.sv
// rtl/dot_product_accum.sv - sums N_TERMS signed products and hands the result over valid/ready
// Optional saturation and sticky overflow flag under DOT_PRODUCT_ACCUM_SAT_EN.
module dot_product_accum
  import dot_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum_data,
  input  logic              sum_ready,
  output logic              overflow
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  logic [0:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;

  logic             w_xfer;
  logic             w_last;
  logic             w_clamp;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_add;

  assign prod_ready = (r_state == ST_ACCUM);
  assign sum_valid  = (r_state == ST_HOLD);
  assign sum_data   = r_sum;
  assign w_xfer     = prod_valid && prod_ready;
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_ext      = ACC_W'(sext_prod(prod_data));

  sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
    .i_a     (r_acc),
    .i_b     (w_ext),
    .o_sum   (w_add),
    .o_clamp (w_clamp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == ST_ACCUM) begin
      if (w_xfer) begin
        if (w_last) begin
          r_sum   <= w_add;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= ST_HOLD;
        end else begin
          r_acc <= w_add;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end else if (sum_ready) begin
      r_state <= ST_ACCUM;
    end
  end

`ifdef DOT_PRODUCT_ACCUM_SAT_EN
  logic r_ovf;

  // The first product of a result restarts the flag; later ones only accumulate into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_ovf <= 1'b0;
    end else if (w_xfer) begin
      r_ovf <= (r_cnt == '0) ? w_clamp : (r_ovf | w_clamp);
    end
  end

  assign overflow = r_ovf;
`else
  assign overflow = w_clamp;
`endif

endmodule

// File: tb/tb_dot_product_accum.sv
// tb/tb_dot_product_accum.sv - directed self-checking bench for dot_product_accum (three parameter sets)
module tb_dot_product_accum;

  logic clk;
  logic rst_n;
  logic clear;

  logic       pv [3];
  logic [7:0] pd [3];
  logic       pr [3];
  logic       sv [3];
  logic       sr [3];
  logic       ov [3];

  logic signed [11:0] sd0;
  logic signed [7:0]  sd1;
  logic signed [11:0] sd2;

  int n_vec = 0;
  int n_bad = 0;

  dot_product_accum #(.N_TERMS(4), .ACC_W(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .prod_valid(pv[0]), .prod_data(pd[0]), .prod_ready(pr[0]),
    .sum_valid(sv[0]), .sum_data(sd0), .sum_ready(sr[0]), .overflow(ov[0])
  );

  dot_product_accum #(.N_TERMS(3), .ACC_W(8)) u_dut_w8 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .prod_valid(pv[1]), .prod_data(pd[1]), .prod_ready(pr[1]),
    .sum_valid(sv[1]), .sum_data(sd1), .sum_ready(sr[1]), .overflow(ov[1])
  );

  dot_product_accum #(.N_TERMS(1), .ACC_W(12)) u_dut_n1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .prod_valid(pv[2]), .prod_data(pd[2]), .prod_ready(pr[2]),
    .sum_valid(sv[2]), .sum_data(sd2), .sum_ready(sr[2]), .overflow(ov[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sum_of(input int idx);
    if (idx == 0) return int'(sd0);
    if (idx == 1) return int'(sd1);
    return int'(sd2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product and return #1 after the edge that accepted it.
  task automatic send(input int idx, input int data);
    int n;
    n = 0;
    pv[idx] = 1'b1;
    pd[idx] = 8'(data);
    while (!pr[idx] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_eq("send_timeout", 0, 1);
    tick();
    pv[idx] = 1'b0;
  endtask

  task automatic take(input int idx);
    sr[idx] = 1'b1;
    tick();
    sr[idx] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; pd[i] = 8'd0; sr[i] = 1'b0;
    end
    tick();
    tick();
    check_eq("rst_prod_ready", int'(pr[0]), 1);
    check_eq("rst_sum_valid", int'(sv[0]), 0);
    check_eq("rst_sum_data", sum_of(0), 0);
    check_eq("rst_overflow", int'(ov[0]), 0);
    rst_n = 1'b1;
    tick();

    // Reset asserted while a result is held
    send(0, 3); send(0, -6); send(0, 10); send(0, 1);
    check_eq("hold_sum_valid", int'(sv[0]), 1);
    check_eq("hold_sum_data", sum_of(0), 8);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_sum_valid", int'(sv[0]), 0);
    check_eq("async_rst_sum_data", sum_of(0), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-pressure: result must stay put and block new products
    send(0, 64); send(0, 64); send(0, -64); send(0, -1);
    check_eq("bp_sum_data", sum_of(0), 63);
    pv[0] = 1'b1;
    pd[0] = 8'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_sum_valid_held", int'(sv[0]), 1);
      check_eq("bp_prod_ready_low", int'(pr[0]), 0);
    end
    check_eq("bp_sum_data_stable", sum_of(0), 63);
    sr[0] = 1'b1;
    tick();
    sr[0] = 1'b0;
    pv[0] = 1'b0;
    check_eq("bp_prod_ready_after", int'(pr[0]), 1);
    check_eq("bp_sum_valid_after", int'(sv[0]), 0);
    send(0, 2); send(0, 2); send(0, 2); send(0, 2);
    check_eq("bp_not_consumed", sum_of(0), 8);
    take(0);

    // Bubbles between products
    for (int i = 0; i < 3; i++) begin
      send(0, -8);
      tick();
    end
    check_eq("bub_not_early", int'(sv[0]), 0);
    send(0, -8);
    check_eq("bub_latency", int'(sv[0]), 1);
    check_eq("bub_sum_data", sum_of(0), -32);
    check_eq("bub_sum_hex", int'(sd0[11:0]), 'hFE0);
    take(0);

    // clear discards partial sum and the product presented with it
    send(0, 5); send(0, 7);
    clear = 1'b1;
    pv[0] = 1'b1;
    pd[0] = 8'd9;
    tick();
    clear = 1'b0;
    pv[0] = 1'b0;
    send(0, 1); send(0, 1); send(0, 1); send(0, 1);
    check_eq("clr_sum_data", sum_of(0), 4);
    take(0);

    // ACC_W=8, N_TERMS=3: saturation or wrap depending on build
    send(1, 64); send(1, 64); send(1, 64);
    check_eq("w8_sum_valid", int'(sv[1]), 1);
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
    check_eq("sat_sum_data", sum_of(1), 127);
    check_eq("sat_overflow", int'(ov[1]), 1);
`else
    check_eq("wrap_sum_data", sum_of(1), -64);
    check_eq("wrap_overflow", int'(ov[1]), 0);
`endif
    take(1);
    send(1, -1); send(1, -1); send(1, -1);
    check_eq("w8_second_sum", sum_of(1), -3);
    check_eq("w8_second_overflow", int'(ov[1]), 0);
    take(1);

    // N_TERMS=1 stream with sum_ready held high
    sr[2] = 1'b1;
    pv[2] = 1'b1;
    pd[2] = 8'(-5);
    tick();
    check_eq("n1_first_valid", int'(sv[2]), 1);
    check_eq("n1_first_sum", sum_of(2), -5);
    pd[2] = 8'd7;
    tick();
    check_eq("n1_idle_valid", int'(sv[2]), 0);
    check_eq("n1_idle_ready", int'(pr[2]), 1);
    tick();
    pv[2] = 1'b0;
    check_eq("n1_second_valid", int'(sv[2]), 1);
    check_eq("n1_second_sum", sum_of(2), 7);
    tick();
    sr[2] = 1'b0;
    check_eq("n1_drain_valid", int'(sv[2]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
